// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, per-cycle
// actions and the hard-wired zero register.
package hazard_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Exactly one action is taken per cycle, chosen by priority.
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_LOAD_USE,
    ACT_WAIT,
    ACT_REDIR
  } action_e;

  function automatic logic [1:0] state_after(input action_e act);
    case (act)
      ACT_WAIT:     return ST_MEM_WAIT;
      ACT_REDIR:    return ST_FLUSH;
      ACT_LOAD_USE: return ST_LU_STALL;
      default:      return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles; flags expiry once MAX_WAIT
// cycles have been spent waiting on a single access.
module mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic incr,
  output logic expired
);

  localparam int TW = $clog2(MAX_WAIT + 1);

  logic [TW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (incr)  cnt_q <= cnt_q + TW'(1);
  end

  assign expired = (cnt_q == TW'(MAX_WAIT));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, data-memory
// freezes with timeout, and wrong-path flushes, plus saturating counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_ifid,
  input  logic [4:0]       rt_ifid,
  input  logic             uses_rt_ifid,
  input  logic [4:0]       rt_idex,
  input  logic             mem_read_idex,
  input  logic             jump_exmem,
  input  logic             branch_exmem,
  input  logic             zero_exmem,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [1:0]       state_q;
  logic             mem_timeout_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic    timer_expired;
  logic    mem_wait;
  logic    redir;
  logic    luhaz;
  action_e action;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .clear  (~mem_wait),
    .incr   (mem_wait),
    .expired(timer_expired)
  );

  assign mem_wait = dmem_req & ~dmem_ready & ~timer_expired;
  assign redir    = jump_exmem | (branch_exmem & zero_exmem);

  // The load has already advanced out of ID/EX while in LU_STALL.
  assign luhaz = mem_read_idex & (rt_idex != REG_ZERO) & (state_q != ST_LU_STALL) &
                 ((rt_idex == rs_ifid) | (uses_rt_ifid & (rt_idex == rt_ifid)));

  always_comb begin
    action = ACT_NONE;
    if (mem_wait)   action = ACT_WAIT;
    else if (redir) action = ACT_REDIR;
    else if (luhaz) action = ACT_LOAD_USE;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      case (action)
        ACT_WAIT: memwb_bubble = 1'b1;
        ACT_REDIR: begin
          pc_write     = 1'b1;
          ifid_write   = 1'b1;
          ifid_flush   = 1'b1;
          idex_write   = 1'b1;
          idex_bubble  = 1'b1;
          exmem_write  = 1'b1;
          exmem_bubble = 1'b1;
        end
        ACT_LOAD_USE: begin
          idex_write  = 1'b1;
          idex_bubble = 1'b1;
          exmem_write = 1'b1;
        end
        default: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
      flush_q       <= '0;
    end else begin
      state_q <= state_after(action);
      if (timer_expired) mem_timeout_q <= 1'b1;
      if ((action == ACT_WAIT || action == ACT_LOAD_USE) && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (action == ACT_REDIR && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

  // EX/MEM was bubbled on the redirect, so no redirect can be resolved in FLUSH.
  a_no_redir_in_flush : assert property (
    @(posedge clk) disable iff (!rst) !((state_q == ST_FLUSH) && redir))
    else $error("redirect raised while in FLUSH");

endmodule
